animation_sequencer: RTL and testbench

- Consumer side of the animation frame-limit lookup. Holds the current animation index, drives it to the lookup, and takes back the frame limit.
- Steps a frame counter from 0 to that limit at a programmable rate, then wraps.
- Optionally auto-advances to the next animation on wrap, and handles next/prev/pause controls.
- Sits between the input controls and the per-animation segment pattern ROMs. anim_o and frame_o address the pattern ROMs.

---
 rtl/animation_pkg.sv | 28 ++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/animation_sequencer.sv | 92 +++++++++
 tb/tb_animation_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/animation_pkg.sv
// Shared types and constants for the animation sequencer and the frame-limit lookup.
package animation_pkg;

    localparam int unsigned ANI_W         = 6;
    localparam int unsigned NUM_ANI       = 36;
    localparam int unsigned SPEED_W       = 3;
    localparam logic [ANI_W-1:0] LIMIT_DEFAULT = 6'd63;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_PAUSE
    } state_t;

    // Step an animation index up or down, wrapping inside 0..num-1.
    function automatic logic [ANI_W-1:0] anim_step(input logic [ANI_W-1:0] cur,
                                                   input logic up,
                                                   input int unsigned num);
        logic [ANI_W-1:0] last;
        last = ANI_W'(num - 1);
        if (up) begin
            anim_step = (cur >= last) ? '0 : cur + 1'b1;
        end else begin
            anim_step = (cur == '0) ? last : cur - 1'b1;
        end
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Frame-rate prescaler: counts while running and strobes when the speed-dependent
// terminal value is reached. The strobe is combinational; the caller registers it.
module tick_prescaler
    import animation_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1048576,
    parameter int unsigned PRESC_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               run,
    input  logic               clr,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;
    logic [PRESC_W-1:0] term;

    // Terminal compare uses >= so a speed increase mid-count fires on the next edge.
    always_comb begin
        term = PRESC_W'((BASE_DIV >> speed) - 32'd1);
        tick = ena & run & ~clr & (cnt >= term);
    end

    // Counter: cleared on load or terminal hit, held while paused or disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (ena) begin
            if (clr || tick) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/animation_sequencer.sv
// Animation sequencer: holds the animation index, steps frames up to the looked-up
// limit, and handles auto-advance, next/prev buttons and pause.
module animation_sequencer
    import animation_pkg::*;
#(
    parameter int unsigned NUM_ANI  = animation_pkg::NUM_ANI,
    parameter int unsigned BASE_DIV = 1048576,
    parameter int unsigned PRESC_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [SPEED_W-1:0] speed,
    input  logic               auto_mode,
    input  logic               pause,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic [ANI_W-1:0]   limit_i,
    output logic [ANI_W-1:0]   anim_o,
    output logic [ANI_W-1:0]   frame_o,
    output logic               tick_o,
    output logic               wrap_o
);

    state_t state;
    logic   next_q, prev_q;
    logic   hit;
    logic   edge_next, edge_prev, btn_go;
    logic   step, do_wrap;

    tick_prescaler #(
        .BASE_DIV (BASE_DIV),
        .PRESC_W  (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .run   (state == ST_RUN),
        .clr   (state == ST_LOAD),
        .speed (speed),
        .tick  (hit)
    );

    // Button edges and frame-step decode; simultaneous next+prev cancel out.
    always_comb begin
        edge_next = btn_next & ~next_q;
        edge_prev = btn_prev & ~prev_q;
        btn_go    = edge_next ^ edge_prev;
        step      = hit & (state == ST_RUN);
        // >= guards against a limit that is stale for the current index.
        do_wrap   = step & (frame_o >= limit_i);
    end

    // Sequencer FSM with registered outputs; button changes win over auto-advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_LOAD;
            anim_o  <= '0;
            frame_o <= '0;
            tick_o  <= 1'b0;
            wrap_o  <= 1'b0;
            next_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else if (!ena) begin
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            next_q <= btn_next;
            prev_q <= btn_prev;
            tick_o <= step;
            wrap_o <= do_wrap;

            if (state == ST_LOAD) begin
                frame_o <= '0;
            end else if (step) begin
                frame_o <= do_wrap ? '0 : frame_o + 1'b1;
            end

            state <= pause ? ST_PAUSE : ST_RUN;

            if (btn_go) begin
                anim_o  <= anim_step(anim_o, edge_next, NUM_ANI);
                frame_o <= '0;
                state   <= ST_LOAD;
            end else if (do_wrap && auto_mode) begin
                anim_o <= anim_step(anim_o, 1'b1, NUM_ANI);
                state  <= ST_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_animation_sequencer.sv
// Directed bench for animation_sequencer with a small frame-limit lookup model.
module tb_animation_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] speed;
    logic       auto_mode;
    logic       pause;
    logic       btn_next;
    logic       btn_prev;
    logic [5:0] limit_i;
    logic [5:0] anim_o;
    logic [5:0] frame_o;
    logic       tick_o;
    logic       wrap_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Lookup model: anim 0 -> 9, anim 1 -> 11, anim 35 -> 4, others -> 7.
    always_comb begin
        case (anim_o)
            6'd0:    limit_i = 6'd9;
            6'd1:    limit_i = 6'd11;
            6'd35:   limit_i = 6'd4;
            default: limit_i = 6'd7;
        endcase
    end

    animation_sequencer #(
        .NUM_ANI  (36),
        .BASE_DIV (256),
        .PRESC_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .speed     (speed),
        .auto_mode (auto_mode),
        .pause     (pause),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .limit_i   (limit_i),
        .anim_o    (anim_o),
        .frame_o   (frame_o),
        .tick_o    (tick_o),
        .wrap_o    (wrap_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count edges until tick_o is seen, bounded by maxc.
    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick_o && n < maxc);
        check("tick_seen", {31'd0, tick_o}, 1);
    endtask

    task automatic press(input logic nx, input logic pv);
        btn_next = nx;
        btn_prev = pv;
        cyc(1);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc(1);
    endtask

    initial begin
        int n;
        int ticks;
        rst = 1'b1; ena = 1'b1; speed = 3'd0; auto_mode = 1'b0; pause = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0;
        cyc(2);
        check("rst_anim", anim_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_wrap", wrap_o, 0);

        // Count and wrap: one LOAD edge + 256 RUN edges to the first tick.
        rst = 1'b0;
        wait_tick(300, n);
        check("first_period", n, 257);
        check("first_frame", frame_o, 1);
        for (int i = 2; i <= 10; i++) begin
            wait_tick(300, n);
            check("period", n, 256);
            check("frame", frame_o, (i == 10) ? 0 : i);
            check("wrap", wrap_o, (i == 10) ? 1 : 0);
        end
        check("anim_no_auto", anim_o, 0);

        // Auto-advance: anim 0 wraps after 10 ticks, anim 1 after 12.
        auto_mode = 1'b1;
        for (int i = 1; i <= 10; i++) wait_tick(300, n);
        check("auto_anim1", anim_o, 1);
        check("auto_frame0", frame_o, 0);
        check("auto_wrap", wrap_o, 1);
        for (int i = 1; i <= 11; i++) wait_tick(300, n);
        check("anim1_last", frame_o, 11);
        wait_tick(300, n);
        check("auto_anim2", anim_o, 2);
        auto_mode = 1'b0;

        // Buttons.
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("prev_to0", anim_o, 0);
        press(1'b0, 1'b1);
        check("prev_wrap", anim_o, 35);
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        check("next_x3", anim_o, 2);
        btn_next = 1'b1;
        cyc(100);
        btn_next = 1'b0;
        cyc(1);
        check("next_held", anim_o, 3);
        press(1'b1, 1'b1);
        check("both_edges", anim_o, 3);

        // Auto-advance from the last index (limit 4) wraps to 0.
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
        check("at35", anim_o, 35);
        auto_mode = 1'b1;
        for (int i = 1; i <= 4; i++) wait_tick(300, n);
        check("anim35_last", frame_o, 4);
        wait_tick(300, n);
        check("auto_35_to0", anim_o, 0);
        check("auto_35_wrap", wrap_o, 1);
        auto_mode = 1'b0;

        // Pause at frame 3.
        for (int i = 1; i <= 3; i++) wait_tick(300, n);
        check("pre_pause_frame", frame_o, 3);
        pause = 1'b1;
        ticks = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1);
            if (tick_o) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check("pause_frame", frame_o, 3);
        press(1'b1, 1'b0);
        check("pause_next_anim", anim_o, 1);
        check("pause_next_frame", frame_o, 0);
        // One PAUSE->RUN edge, then 256 counting edges (prescaler cleared by LOAD).
        pause = 1'b0;
        wait_tick(300, n);
        check("unpause_period", n, 257);
        check("unpause_frame", frame_o, 1);

        // Speed 3 gives a 32-cycle period.
        speed = 3'd3;
        wait_tick(300, n);
        check("speed3_period", n, 32);
        wait_tick(300, n);
        check("speed3_period2", n, 32);
        check("speed3_frame", frame_o, 3);
        speed = 3'd0;
        cyc(100);
        check("slow_no_tick", tick_o, 0);
        speed = 3'd3;
        cyc(1);
        check("speed_switch_tick", tick_o, 1);
        check("speed_switch_frame", frame_o, 4);

        // ena low freezes everything.
        ena = 1'b0;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (tick_o) ticks++;
        end
        check("ena_ticks", ticks, 0);
        check("ena_frame", frame_o, 4);
        check("ena_anim", anim_o, 1);
        ena = 1'b1;
        wait_tick(300, n);
        check("ena_resume_period", n, 32);
        check("ena_resume_frame", frame_o, 5);

        // Reset mid-frame: anim 5, frame 3, prescaler 120.
        speed = 3'd0;
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) wait_tick(300, n);
        cyc(120);
        check("pre_rst_anim", anim_o, 5);
        check("pre_rst_frame", frame_o, 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_anim", anim_o, 0);
        check("async_rst_frame", frame_o, 0);
        check("async_rst_wrap", wrap_o, 0);
        cyc(2);
        rst = 1'b0;
        wait_tick(300, n);
        check("post_rst_period", n, 257);
        check("post_rst_frame", frame_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
